up_counter_4bit: RTL and testbench

Synchronous 4-bit up-counter with a parameterised modulus, defaulting to decade (mod-10, 0→9→0) counting. It is a leaf timing/sequencing primitive, used wherever a BCD digit counter or a divide-by-N tick source is needed. It exposes the count value and a terminal-count flag so that instances can be cascaded.

---
 rtl/up_counter_4bit_pkg.sv | 12 +
 rtl/up_counter_4bit.sv | 63 ++++++
 tb/tb_up_counter_4bit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/up_counter_4bit_pkg.sv
// up_counter_4bit_pkg
// Shared defaults for the modulus counter. Cascaded digit counters pull their
// width and modulus from here, so a whole chain changes from one place.
// No ports (package).
package up_counter_4bit_pkg;

  // Register width of one counter digit.
  localparam int CNT_WIDTH_DEFAULT   = 4;
  // Decade counting (0..9) gives one BCD digit.
  localparam int CNT_MODULUS_DEFAULT = 10;

endpackage : up_counter_4bit_pkg

// File: rtl/up_counter_4bit.sv
// up_counter_4bit
// Synchronous up-counter with a parameterised modulus. It counts
// 0 .. MODULUS-1 and then wraps to 0. TC flags the last count so that
// instances can be cascaded as BCD digits or used as divide-by-N ticks.
//
// Parameters
//   WIDTH    counter register width in bits
//   MODULUS  count range is 0 .. MODULUS-1, legal range 2 .. 2**WIDTH
// Ports
//   CLK  in   single clock, rising-edge
//   RST  in   synchronous, active-high reset; forces the count to 0
//   OUT  out  registered count value
//   TC   out  terminal count: combinational, high when OUT == MODULUS-1
//             and RST is low
module up_counter_4bit
  import up_counter_4bit_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int MODULUS = CNT_MODULUS_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [WIDTH-1:0] OUT,
  output logic             TC
);

  // Reject a modulus the register cannot hold, or one that cannot count.
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("up_counter_4bit: MODULUS must lie in 2 .. 2**WIDTH");
    end
  endgenerate

  // Last legal count value.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Next-state: reset and wrap both go to 0. Any value above CNT_MAX
  // (upset or bad power-up value) also returns to 0 rather than running
  // on through the unused codes.
  always_comb begin
    out_d = out_q + WIDTH'(1);
    if (RST) begin
      out_d = '0;
    end else if (out_q == CNT_MAX) begin
      out_d = '0;
    end else if (out_q > CNT_MAX) begin
      out_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    out_q <= out_d;
  end

  assign OUT = out_q;
  // TC is masked during reset, so a cascaded downstream counter does not
  // see a spurious carry while the chain is being cleared.
  assign TC  = (out_q == CNT_MAX) && !RST;

endmodule : up_counter_4bit

// File: tb/tb_up_counter_4bit.sv
// tb_up_counter_4bit
// Directed bench for up_counter_4bit: a default mod-10 instance and a
// mod-16 instance sharing one clock. Expected values are hand-computed.
module tb_up_counter_4bit;

  logic       clk;
  logic       rst;
  logic [3:0] out_10;
  logic       tc_10;
  logic       rst16;
  logic [3:0] out_16;
  logic       tc_16;

  int checks   = 0;
  int failures = 0;
  int tc_pulses;

  up_counter_4bit dut (
    .CLK (clk),
    .RST (rst),
    .OUT (out_10),
    .TC  (tc_10)
  );

  up_counter_4bit #(.WIDTH(4), .MODULUS(16)) dut16 (
    .CLK (clk),
    .RST (rst16),
    .OUT (out_16),
    .TC  (tc_16)
  );

  // ---------------- clock / reset ----------------
  // The clock stays low for the first 10 ns so reset can be set up with
  // no edge present; the first rising edge is at 15 ns.
  initial begin
    clk = 1'b0;
    #10;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  // One edge, then sample 1 ns later, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst   = 1'b0;
    rst16 = 1'b1;
    #5;
    rst = 1'b1;

    // Reset held for 38 edges: count pinned at 0, TC masked.
    for (int i = 0; i < 38; i++) begin
      step();
      chk("rst_out", 32'(out_10), 32'd0);
      chk("rst_tc", 32'(tc_10), 32'd0);
    end

    // Free-running: 38 edges give 1..9,0,1..9,0,1..9,0,1..8.
    rst = 1'b0;
    #1;
    chk("rel_out0", 32'(out_10), 32'd0);
    tc_pulses = 0;
    for (int n = 1; n <= 38; n++) begin
      step();
      chk("cnt_out", 32'(out_10), 32'(n % 10));
      chk("cnt_tc", 32'(tc_10), 32'((n % 10) == 9));
      if (tc_10) tc_pulses++;
    end
    chk("tc_pulses", 32'(tc_pulses), 32'd3);
    chk("cnt_final", 32'(out_10), 32'd8);

    // Reach 9, then reset on the terminal value: goes to 0, not 1.
    step();
    chk("at9_out", 32'(out_10), 32'd9);
    chk("at9_tc", 32'(tc_10), 32'd1);
    rst = 1'b1;
    #1;
    chk("tc_mask", 32'(tc_10), 32'd0);
    chk("rst_noedge", 32'(out_10), 32'd9);
    step();
    chk("rst9_out", 32'(out_10), 32'd0);
    chk("rst9_tc", 32'(tc_10), 32'd0);
    rst = 1'b0;

    // Count to 4, reset mid-count, then resume from 0.
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("to4_out", 32'(out_10), 32'(n));
    end
    rst = 1'b1;
    step();
    chk("rst4_out", 32'(out_10), 32'd0);
    rst = 1'b0;
    step();
    chk("after4_out1", 32'(out_10), 32'd1);
    step();
    chk("after4_out2", 32'(out_10), 32'd2);

    // Illegal state: load 12 through the next-state net for one edge.
    @(negedge clk);
    force dut.out_d = 4'd12;
    step();
    release dut.out_d;
    #1;
    chk("ill_out", 32'(out_10), 32'd12);
    chk("ill_tc", 32'(tc_10), 32'd0);
    step();
    chk("ill_recover", 32'(out_10), 32'd0);
    step();
    chk("ill_next", 32'(out_10), 32'd1);

    // Mod-16 instance: 17 edges after reset, wraps 15 -> 0 and ends at 1.
    chk("m16_rst_out", 32'(out_16), 32'd0);
    chk("m16_rst_tc", 32'(tc_16), 32'd0);
    rst16 = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      step();
      chk("m16_out", 32'(out_16), 32'(n % 16));
      chk("m16_tc", 32'(tc_16), 32'((n % 16) == 15));
    end
    chk("m16_final", 32'(out_16), 32'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_up_counter_4bit
